// File: rtl/prog_seq_pkg.sv
// Shared types and default widths for the program sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_seq_pkg;

    localparam int ADDR_W  = 8;
    localparam int JADDR_W = 4;

    typedef logic [ADDR_W-1:0] pm_addr_t;

    // Source of the next program-memory address, listed in priority order.
    typedef enum logic [2:0] {
        SEL_RESET = 3'd0,
        SEL_HOLD  = 3'd1,
        SEL_JMP   = 3'd2,
        SEL_JNZ   = 3'd3,
        SEL_INC   = 3'd4
    } next_sel_e;

endpackage

// File: rtl/prog_seq_next_sel.sv
// Priority encoder choosing the source of the next program address.
// Latency: purely combinational, zero cycles.
// Backpressure: none; hold is the only stall and just picks SEL_HOLD.
module prog_seq_next_sel
    import prog_seq_pkg::*;
(
    input  logic      sync_reset,
    input  logic      hold,
    input  logic      jmp,
    input  logic      jmp_nz,
    input  logic      dont_jmp,
    output next_sel_e sel
);

    // Reset beats hold, hold beats jumps, jmp beats jmp_nz; increment otherwise.
    always_comb begin
        sel = SEL_INC;
        if (!sync_reset) begin
            sel = SEL_RESET;
        end else if (hold) begin
            sel = SEL_HOLD;
        end else if (jmp) begin
            sel = SEL_JMP;
        end else if (jmp_nz && !dont_jmp) begin
            sel = SEL_JNZ;
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Program counter and next-address mux for instruction fetch (optional stall via PROG_SEQ_HOLD_EN).
// Latency: pm_addr combinational from controls; pc follows pm_addr one edge later.
// Backpressure: none by default; with PROG_SEQ_HOLD_EN, hold freezes pc and pm_addr = pc.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int ADDR_W  = prog_seq_pkg::ADDR_W,
    parameter int JADDR_W = prog_seq_pkg::JADDR_W
) (
    input  logic               clk,
    input  logic               sync_reset,
    input  logic               jmp,
    input  logic               jmp_nz,
    input  logic               dont_jmp,
`ifdef PROG_SEQ_HOLD_EN
    input  logic               hold,
`endif
    input  logic [JADDR_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0]  pm_addr,
    output logic [ADDR_W-1:0]  pc
);

    next_sel_e         sel;
    logic              hold_int;
    logic [ADDR_W-1:0] jmp_tgt;

`ifdef PROG_SEQ_HOLD_EN
    assign hold_int = hold;
`else
    assign hold_int = 1'b0;
`endif

    // Jump target: the nibble lands in the top bits, low bits zero.
    assign jmp_tgt = ADDR_W'(jmp_addr) << (ADDR_W - JADDR_W);

    prog_seq_next_sel u_next_sel (
        .sync_reset (sync_reset),
        .hold       (hold_int),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz),
        .dont_jmp   (dont_jmp),
        .sel        (sel)
    );

    // Address mux; increment wraps naturally at the address width.
    always_comb begin
        pm_addr = '0;
        case (sel)
            SEL_RESET: pm_addr = '0;
            SEL_HOLD:  pm_addr = pc;
            SEL_JMP:   pm_addr = jmp_tgt;
            SEL_JNZ:   pm_addr = jmp_tgt;
            SEL_INC:   pm_addr = pc + ADDR_W'(1);
            default:   pm_addr = '0;
        endcase
    end

    // Program counter captures the address presented this cycle.
    always_ff @(posedge clk) begin
        if (!sync_reset) begin
            pc <= '0;
        end else begin
            pc <= pm_addr;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed test-plan cases plus random controls.
// Latency: checks pm_addr in the same cycle and pc one edge later.
// Backpressure: exercises hold only when PROG_SEQ_HOLD_EN is defined.
module tb_prog_sequencer;
    import prog_seq_pkg::*;

    logic       clk;
    logic       sync_reset;
    logic       jmp;
    logic       jmp_nz;
    logic       dont_jmp;
    logic [3:0] jmp_addr;
    pm_addr_t   pm_addr;
    pm_addr_t   pc;
`ifdef PROG_SEQ_HOLD_EN
    logic       hold;
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Reference state: what the program counter should hold.
    int model_pc  = 0;
    bit pc_known  = 1'b0;

    prog_sequencer dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .jmp        (jmp),
        .jmp_nz     (jmp_nz),
        .dont_jmp   (dont_jmp),
`ifdef PROG_SEQ_HOLD_EN
        .hold       (hold),
`endif
        .jmp_addr   (jmp_addr),
        .pm_addr    (pm_addr),
        .pc         (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, act, exp);
        end
    endtask

    // Next address from the written rules, in plain integer arithmetic.
    function automatic int ref_next(input bit r, input bit h, input bit j,
                                    input bit jnz, input bit dj, input int ja);
        if (!r)              return 0;
        if (HOLD_EN && h)    return model_pc;
        if (j)               return ja * 16;
        if (jnz && !dj)      return ja * 16;
        return (model_pc + 1) % 256;
    endfunction

    // One cycle: drive at negedge, check shortly after, advance model at posedge.
    // lit >= 0 adds a check against a hand-derived constant.
    task automatic step(input bit r, input bit j, input bit jnz, input bit dj,
                        input int ja, input bit h, input int lit, input string tag);
        int exp;
        @(negedge clk);
        sync_reset = r;
        jmp        = j;
        jmp_nz     = jnz;
        dont_jmp   = dj;
        jmp_addr   = 4'(ja);
`ifdef PROG_SEQ_HOLD_EN
        hold       = h;
`endif
        #1;
        exp = ref_next(r, h, j, jnz, dj, ja);
        chk({tag, "_pm"}, pm_addr, 8'(exp));
        if (pc_known) chk({tag, "_pc"}, pc, 8'(model_pc));
        if (lit >= 0) chk({tag, "_lit"}, pm_addr, 8'(lit));
        @(posedge clk);
        if (pc_known || !r) begin
            model_pc = exp;
            pc_known = 1'b1;
        end
    endtask

    initial begin
        sync_reset = 1'b0;
        jmp        = 1'b0;
        jmp_nz     = 1'b0;
        dont_jmp   = 1'b0;
        jmp_addr   = 4'h0;
`ifdef PROG_SEQ_HOLD_EN
        hold       = 1'b0;
`endif

        // Reset then run
        step(0, 0, 0, 0, 0, 0, 8'h00, "rst");
        step(1, 0, 0, 0, 0, 0, 8'h01, "run1");
        // Unconditional jump from pc=0x01
        step(1, 1, 0, 0, 4'hA, 0, 8'hA0, "jmp");
        step(1, 0, 0, 0, 0, 0, 8'hA1, "jmp_inc");
        // Conditional jump taken, then suppressed, then idle steps
        step(1, 0, 1, 0, 4'h1, 0, 8'h10, "jnz_take");
        step(1, 0, 1, 1, 4'h1, 0, 8'h11, "jnz_skip");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 8'h12 + i, "idle");
        // Priority: reset dominates, then jmp over jmp_nz/dont_jmp
        step(0, 1, 1, 0, 4'h9, 0, 8'h00, "pri_rst");
        step(1, 1, 1, 0, 4'h9, 0, 8'h90, "pri_rel");
        step(1, 1, 1, 1, 4'hB, 0, 8'hB0, "pri_jmp");
        // Wrap at top of address space
        step(1, 1, 0, 0, 4'hF, 0, 8'hF0, "wrap_jmp");
        for (int i = 1; i <= 15; i++) step(1, 0, 0, 0, 0, 0, 8'hF0 + i, "wrap_inc");
        step(1, 0, 0, 0, 0, 0, 8'h00, "wrap0");
        step(1, 0, 0, 0, 0, 0, 8'h01, "wrap1");
`ifdef PROG_SEQ_HOLD_EN
        // Hold beats jmp and freezes pc
        step(1, 1, 0, 0, 4'h2, 0, 8'h20, "h_jmp");
        step(1, 0, 0, 0, 0, 0, 8'h21, "h_inc");
        step(1, 1, 0, 0, 4'h7, 1, 8'h21, "hold1");
        step(1, 1, 0, 0, 4'h7, 1, 8'h21, "hold2");
        chk("hold_pc", pc, 8'h21);
        step(1, 0, 0, 0, 0, 0, 8'h22, "h_rel");
        // Reset beats hold
        step(0, 0, 0, 0, 0, 1, 8'h00, "h_rst");
`endif
        // Random controls against the reference model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 15) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                 -1, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Program-counter and next-address logic for the microprocessor's instruction fetch path. Each cycle it presents the program-memory address `pm_addr` from one of four sources: reset, unconditional jump, conditional jump-if-not-zero, or sequential increment. It then latches that address into the internal program counter on the rising clock edge. It sits between instruction decode (jump controls, IR low nibble, ALU zero flag) and program memory.

## Interface
Parameters:
- `ADDR_W`, default 8: program-memory address width.
- `JADDR_W`, default 4: jump-target nibble width; must be ≤ `ADDR_W`.

Ports:
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `sync_reset` input, 1 bit: reset, synchronous and active-low.
- `jmp` input, 1 bit: unconditional jump request.
- `jmp_nz` input, 1 bit: conditional jump request (jump if not zero).
- `dont_jmp` input, 1 bit: zero flag from the datapath; 1 suppresses `jmp_nz`.
- `jmp_addr` input, `JADDR_W` bits: jump-target nibble, normally IR[3:0].
- `hold` input, 1 bit: stall request. Present only with `PROG_SEQ_HOLD_EN` (see Configuration).
- `pm_addr` output, `ADDR_W` bits: combinational program-memory address for the current cycle (the next PC).
- `pc` output, `ADDR_W` bits: registered program counter, i.e. the address fetched last cycle.

## Operation
- `pm_addr` is combinational. It uses this priority, highest first:
  1. `sync_reset == 0` → `pm_addr = 0`.
  2. `hold == 1` (only if enabled) → `pm_addr = pc`.
  3. `jmp == 1` → `pm_addr = {jmp_addr, {ADDR_W-JADDR_W{1'b0}}}`. Example: nibble 0xA gives 0xA0.
  4. `jmp_nz == 1 && dont_jmp == 0` → `pm_addr` takes the same jump-target form as case 3.
  5. Otherwise → `pm_addr = pc + 1`, modulo 2^`ADDR_W`, so 0xFF wraps to 0x00.
- `pc <= pm_addr` on every rising edge.
- `jmp` overrides `jmp_nz` and `dont_jmp`. With `jmp_nz == 1` and `dont_jmp == 1`, the sequencer increments.
- Reset dominates every other input, so all controls asserted together with `sync_reset == 0` give `pm_addr = 0`.
- Before the first reset, `pc` is undefined. `pm_addr` is then defined only while `sync_reset == 0`.

## Timing
- Zero-cycle latency from control inputs to `pm_addr`. One cycle from `pm_addr` to `pc`.
- Reset: on the first edge with `sync_reset == 0`, `pc` becomes 0. `pm_addr` is 0 combinationally for as long as reset is low.
- First cycle after reset releases: `pm_addr = 0x01` unless a jump is requested.
- Reset asserted mid-sequence takes effect in that same cycle on `pm_addr` and at that same edge on `pc`.
- No handshakes; every control input is sampled every cycle.
- Control inputs must be stable before the rising edge. No combinational path exists from `pm_addr` back to any input.

## Configuration
- `PROG_SEQ_HOLD_EN` defined:
  - `hold` port exists with priority 2.
  - While `hold == 1`, `pm_addr = pc` and `pc` is unchanged.
- `PROG_SEQ_HOLD_EN` undefined:
  - No `hold` port.
  - The sequencer advances every cycle.

## Structure
- Package `prog_seq_pkg` contains:
  - `ADDR_W` and `JADDR_W` defaults.
  - `typedef logic [ADDR_W-1:0] pm_addr_t`.
  - Enum `next_sel_e` = {`SEL_RESET`, `SEL_HOLD`, `SEL_JMP`, `SEL_JNZ`, `SEL_INC`}.
- Sub-module `prog_seq_next_sel`: purely combinational priority encoder from the control inputs to `next_sel_e`.
- Top level holds:
  - the address mux driven by `next_sel_e`;
  - the `pc` register.

## Test plan
- Reset then run: `sync_reset = 0` for one cycle → `pm_addr = 0x00`; release with no jumps → `pm_addr = 0x01`.
- Unconditional jump: `pc = 0x01`, `jmp = 1`, `jmp_addr = 0xA` → `pm_addr = 0xA0`; next cycle idle → `pm_addr = 0xA1`.
- Conditional jump:
  - `jmp_nz = 1`, `dont_jmp = 0`, `jmp_addr = 0x1` → `pm_addr = 0x10`.
  - Next cycle `jmp_nz = 1`, `dont_jmp = 1` → `pm_addr = 0x11`.
  - Three idle cycles → `pm_addr` steps 0x12, 0x13, 0x14.
- Priority:
  - `sync_reset = 0` with `jmp = jmp_nz = 1`, `jmp_addr = 0x9` → `pm_addr = 0x00`.
  - Release with the same controls → `pm_addr = 0x90`.
  - `jmp = 1`, `jmp_nz = 1`, `dont_jmp = 1`, `jmp_addr = 0xB` → `pm_addr = 0xB0`.
- Wrap: jump to 0xF0, then 15 idle cycles reach 0xFF; next idle cycle → `pm_addr = 0x00`.
- Hold (`PROG_SEQ_HOLD_EN` defined): `pc = 0x21`, `hold = 1` together with `jmp = 1` for 2 cycles → `pm_addr` stays 0x21 and `pc` stays 0x21; release with idle controls → `pm_addr = 0x22`.
